power_of_n_pipe: RTL and testbench

Parametrised, fully pipelined exponentiation unit computing `x^(2^e)` by repeated squaring. It has a runtime-selectable exponent, a valid/ready handshake with back-pressure, and per-beat exponent tagging. It is the generalised successor of the fixed 4-bit, power-of-eight squaring chain. It sits between a producer issuing `(value, exponent)` beats and a consumer that may stall.

---
 rtl/power_of_n_pipe_if.sv | 29 ++
 rtl/power_of_n_pipe.sv | 70 +++++++
 tb/tb_power_of_n_pipe.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/power_of_n_pipe_if.sv
// Beat-level handshake bundle for power_of_n_pipe: operand/exponent in, tagged result out.
// The pipe sits on the slave side. The producer/consumer pair sits on the master side.
interface power_of_n_pipe_if #(
    parameter int DATA_W = 4,
    parameter int STAGES = 3,
    parameter int EXP_W  = 3
);
    localparam int OUT_W = DATA_W << STAGES;

    logic [DATA_W-1:0] i_value;
    logic [EXP_W-1:0]  i_exp;
    logic              i_status;
    logic              o_ready;
    logic [OUT_W-1:0]  o_value;
    logic [EXP_W-1:0]  o_exp;
    logic              o_clamp;
    logic              o_status;
    logic              i_ready;

    modport slave (
        input  i_value, i_exp, i_status, i_ready,
        output o_ready, o_value, o_exp, o_clamp, o_status
    );

    modport master (
        output i_value, i_exp, i_status, i_ready,
        input  o_ready, o_value, o_exp, o_clamp, o_status
    );
endinterface

// File: rtl/power_of_n_pipe.sv
// Pipelined x^(2^e) by repeated squaring. Stage k squares its value only when k < the beat's
// clamped exponent. A single global enable stalls the whole pipe under output back-pressure.
module power_of_n_pipe #(
    parameter int DATA_W = 4,
    parameter int STAGES = 3,
    parameter int EXP_W  = 3
) (
    input logic              i_clock,
    input logic              i_reset_async_n,
    power_of_n_pipe_if.slave bus
);
    localparam int OUT_W = DATA_W << STAGES;

    logic [STAGES-1:0][OUT_W-1:0] val_q, val_d, src_val;
    logic [STAGES-1:0][EXP_W-1:0] exp_q, exp_d;
    logic [STAGES-1:0]            clamp_q, clamp_d;
    logic [STAGES-1:0]            vld_q, vld_d;
    logic [EXP_W-1:0]             ee_in;
    logic                         clamp_in;
    logic                         en;

    assign clamp_in = bus.i_exp > EXP_W'(STAGES);
    assign ee_in    = clamp_in ? EXP_W'(STAGES) : bus.i_exp;
    assign en       = !vld_q[STAGES-1] || bus.i_ready;

    // Stage inputs. Tags, clamp and valid pass through unchanged, so they are the next state directly.
    assign src_val[0] = OUT_W'(bus.i_value);
    assign exp_d[0]   = ee_in;
    assign clamp_d[0] = clamp_in;
    assign vld_d[0]   = bus.i_status;

    for (genvar k = 1; k < STAGES; k++) begin : g_chain
        assign src_val[k] = val_q[k-1];
        assign exp_d[k]   = exp_q[k-1];
        assign clamp_d[k] = clamp_q[k-1];
        assign vld_d[k]   = vld_q[k-1];
    end

    // Truncation to OUT_W discards only zero bits, since j squarings need DATA_W*2^j bits.
    always_comb begin
        val_d = '0;
        for (int k = 0; k < STAGES; k++) begin
            if (EXP_W'(k) < exp_d[k])
                val_d[k] = OUT_W'(src_val[k] * src_val[k]);
            else
                val_d[k] = src_val[k];
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_async_n) begin
        if (!i_reset_async_n) begin
            val_q   <= '0;
            exp_q   <= '0;
            clamp_q <= '0;
            vld_q   <= '0;
        end else if (en) begin
            val_q   <= val_d;
            exp_q   <= exp_d;
            clamp_q <= clamp_d;
            vld_q   <= vld_d;
        end
    end

    // Invalid slots carry stale data, so gate everything that leaves the block.
    assign bus.o_ready  = en;
    assign bus.o_status = vld_q[STAGES-1];
    assign bus.o_value  = vld_q[STAGES-1] ? val_q[STAGES-1] : '0;
    assign bus.o_exp    = vld_q[STAGES-1] ? exp_q[STAGES-1] : '0;
    assign bus.o_clamp  = vld_q[STAGES-1] & clamp_q[STAGES-1];
endmodule

// File: tb/tb_power_of_n_pipe.sv
// Directed and scoreboarded checks for power_of_n_pipe at DATA_W=4, STAGES=3, EXP_W=3.
module tb_power_of_n_pipe;
    localparam int DATA_W = 4;
    localparam int STAGES = 3;
    localparam int EXP_W  = 3;
    localparam int NRND   = 10000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    power_of_n_pipe_if #(.DATA_W(DATA_W), .STAGES(STAGES), .EXP_W(EXP_W)) bus ();

    power_of_n_pipe #(.DATA_W(DATA_W), .STAGES(STAGES), .EXP_W(EXP_W)) dut (
        .i_clock         (clk),
        .i_reset_async_n (rst_n),
        .bus             (bus)
    );

    typedef struct {
        logic [63:0] v;
        logic [63:0] e;
        logic [63:0] c;
    } beat_t;

    int    total = 0;
    int    passed = 0;
    beat_t q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int v, input int e, input logic s);
        bus.i_value  = DATA_W'(v);
        bus.i_exp    = EXP_W'(e);
        bus.i_status = s;
    endtask

    function automatic logic [63:0] ref_pow(input int x, input int e);
        logic [63:0] r;
        int          n;
        r = 64'(x);
        n = (e > STAGES) ? STAGES : e;
        for (int i = 0; i < n; i++) r = r * r;
        return r;
    endfunction

    initial begin
        int    nxt, got, scnt, sent, cyc;
        logic  sdone;
        beat_t b;
        int    bp_exp[6] = '{1, 4, 9, 16, 25, 36};
        int    bb_v[7]   = '{0, 9, 1, 9, 0, 0, 0};
        logic  bb_s[7]   = '{1, 0, 1, 0, 0, 0, 0};

        drive(0, 0, 0);
        bus.i_ready = 1'b1;
        #2;
        chk("rst_status", bus.o_status, 0);
        chk("rst_value",  bus.o_value, 0);
        chk("rst_ready",  bus.o_ready, 1);
        chk("rst_exp",    bus.o_exp, 0);
        chk("rst_clamp",  bus.o_clamp, 0);
        #10 rst_n = 1'b1;
        tick();

        // Basic powers, back-to-back
        drive(15, 3, 1); tick();
        drive(3, 3, 1);  tick();
        chk("lat_empty", bus.o_status, 0);
        drive(2, 2, 1);  tick();
        chk("p0_status", bus.o_status, 1);
        chk("p0_value",  bus.o_value, 64'd2562890625);
        chk("p0_exp",    bus.o_exp, 3);
        drive(7, 0, 1);  tick();
        chk("p1_value",  bus.o_value, 6561);
        chk("p1_exp",    bus.o_exp, 3);
        drive(0, 0, 0);  tick();
        chk("p2_value",  bus.o_value, 16);
        chk("p2_exp",    bus.o_exp, 2);
        tick();
        chk("p3_status", bus.o_status, 1);
        chk("p3_value",  bus.o_value, 7);
        chk("p3_exp",    bus.o_exp, 0);
        tick();
        chk("p_drain",   bus.o_status, 0);

        // Clamp
        drive(2, 5, 1); tick();
        drive(2, 1, 1); tick();
        drive(0, 0, 0); tick();
        chk("cl_value", bus.o_value, 256);
        chk("cl_exp",   bus.o_exp, 3);
        chk("cl_clamp", bus.o_clamp, 1);
        tick();
        chk("cl2_value", bus.o_value, 4);
        chk("cl2_exp",   bus.o_exp, 1);
        chk("cl2_clamp", bus.o_clamp, 0);
        tick();

        // Back-pressure: stall 4 cycles once the first result is visible
        nxt = 1; got = 0; scnt = 0; sdone = 1'b0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            drive(nxt, 1, nxt <= 6);
            if (!sdone && bus.o_status) begin
                bus.i_ready = 1'b0;
                #1;
                chk("bp_ready", bus.o_ready, 0);
                chk("bp_hold",  bus.o_value, 1);
                scnt++;
                if (scnt == 4) sdone = 1'b1;
            end else begin
                bus.i_ready = 1'b1;
                #1;
                if (bus.o_status) begin
                    chk("bp_out", bus.o_value, 64'(bp_exp[got]));
                    got++;
                end
                if (bus.i_status && bus.o_ready) nxt++;
            end
            tick();
        end
        bus.i_ready = 1'b1;
        drive(0, 0, 0);
        chk("bp_count", 64'(got), 6);
        chk("bp_nodup", bus.o_status, 0);

        // Bubbles: gaps on input must reappear on output, with o_value gated
        for (int c = 0; c < 7; c++) begin
            drive(bb_v[c], 3, bb_s[c]);
            tick();
            if (c >= 2) begin
                chk("bb_status", bus.o_status, 64'(bb_s[c-2]));
                chk("bb_value",  bus.o_value, bb_s[c-2] ? 64'(bb_v[c-2]) : 64'd0);
            end
        end

        // Reset mid-stream
        drive(5, 1, 1); tick();
        drive(6, 1, 1); tick();
        drive(0, 0, 0); tick();
        bus.i_ready = 1'b0;
        #1;
        chk("mr_pre_ready", bus.o_ready, 0);
        chk("mr_pre_value", bus.o_value, 25);
        rst_n = 1'b0;
        #1;
        chk("mr_status", bus.o_status, 0);
        chk("mr_value",  bus.o_value, 0);
        chk("mr_ready",  bus.o_ready, 1);
        chk("mr_exp",    bus.o_exp, 0);
        #3;
        rst_n = 1'b1;
        bus.i_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("mr_stale", bus.o_status, 0);
        end

        // Random traffic against a queue model
        sent = 0; cyc = 0;
        while ((sent < NRND || q.size() > 0) && cyc < 60000) begin
            drive($urandom_range(0, 15), $urandom_range(0, 7),
                  (sent < NRND) && ($urandom_range(0, 3) != 0));
            bus.i_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (bus.o_status && bus.i_ready) begin
                if (q.size() == 0) chk("rnd_spurious", bus.o_status, 0);
                else begin
                    b = q.pop_front();
                    chk("rnd_value", bus.o_value, b.v);
                    chk("rnd_exp",   bus.o_exp, b.e);
                    chk("rnd_clamp", bus.o_clamp, b.c);
                end
            end else if (!bus.o_status) begin
                chk("rnd_gate", bus.o_value, 0);
            end
            if (bus.i_status && bus.o_ready) begin
                b.v = ref_pow(int'(bus.i_value), int'(bus.i_exp));
                b.e = (bus.i_exp > 3'(STAGES)) ? 64'(STAGES) : 64'(bus.i_exp);
                b.c = 64'(bus.i_exp > 3'(STAGES));
                q.push_back(b);
                sent++;
            end
            tick();
            cyc++;
        end
        chk("rnd_sent",  64'(sent), NRND);
        chk("rnd_drain", 64'(q.size()), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
